// File: rtl/tt_vector_player_if.sv
// ----------------------------------------------------------------------------
// tt_vector_player_if
// Bundles the vector-load bus, run control, DUT stimulus/response and the
// result flags of tt_vector_player.
//   slave  : the vector player itself
//   master : the host / bench that loads vectors, starts runs and reads results
// Signals:
//   load_en, load_addr, load_ui, load_uio, load_exp, load_mask : vector write
//   start, num_vec                                          : run control
//   dut_uo                                                  : DUT uo_out
//   ui_drv, uio_drv                                         : DUT ui_in/uio_in
//   busy, done, pass, err_count, first_err_idx              : status
// ----------------------------------------------------------------------------
interface tt_vector_player_if #(
    parameter int IO_W  = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [IO_W-1:0] load_ui;
    logic [IO_W-1:0] load_uio;
    logic [IO_W-1:0] load_exp;
    logic [IO_W-1:0] load_mask;
    logic            start;
    logic [AW:0]     num_vec;
    logic [IO_W-1:0] dut_uo;
    logic [IO_W-1:0] ui_drv;
    logic [IO_W-1:0] uio_drv;
    logic            busy;
    logic            done;
    logic            pass;
    logic [CNT_W-1:0] err_count;
    logic [AW-1:0]   first_err_idx;

    modport slave (
        input  load_en, load_addr, load_ui, load_uio, load_exp, load_mask,
        input  start, num_vec, dut_uo,
        output ui_drv, uio_drv, busy, done, pass, err_count, first_err_idx
    );

    modport master (
        output load_en, load_addr, load_ui, load_uio, load_exp, load_mask,
        output start, num_vec, dut_uo,
        input  ui_drv, uio_drv, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/tt_vector_player.sv
// ----------------------------------------------------------------------------
// tt_vector_player
// Stimulus/response engine for TinyTapeout user projects. Holds DEPTH vectors
// (ui/uio drive, expected uo, compare mask), plays them one per cycle into a
// DUT, compares uo_out LAT edges after each launch and reports a saturating
// mismatch count, the first failing index and pass/done flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   vp   : tt_vector_player_if.slave (load bus, start/num_vec, dut_uo in;
//          ui_drv/uio_drv, busy, done, pass, err_count, first_err_idx out)
// Optional feature macro: VP_HALT_ON_ERR_EN -- stop launching vectors on the
// first mismatch, drain in-flight compares, then finish with pass=0.
// ----------------------------------------------------------------------------
module tt_vector_player #(
    parameter int IO_W  = 8,
    parameter int DEPTH = 16,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    tt_vector_player_if.slave vp
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LCW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IO_W-1:0]  mem_ui_q   [DEPTH];
    logic [IO_W-1:0]  mem_uio_q  [DEPTH];
    logic [IO_W-1:0]  mem_exp_q  [DEPTH];
    logic [IO_W-1:0]  mem_mask_q [DEPTH];
    logic [AW:0]      num_q, num_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [LCW-1:0]   cnt_q, cnt_d;
    logic [IO_W-1:0]  ui_q, ui_d;
    logic [IO_W-1:0]  uio_q, uio_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]    ferr_q, ferr_d;
    logic             pass_q, pass_d;
    logic [AW-1:0]    tag_idx_q [LAT];
    logic [LAT-1:0]   tag_vld_q;

    logic             busy;
    logic             wr_en;
    logic             fwd0;
    logic [IO_W-1:0]  vec0_ui, vec0_uio;
    logic [AW:0]      num_in;
    logic [AW-1:0]    idx_nx;
    logic [AW-1:0]    cmp_idx;
    logic             mismatch;
    logic             halt;
    logic             launch;
    logic [AW-1:0]    launch_idx;

    assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign wr_en = vp.load_en && !busy;

    // A write to entry 0 coinciding with start must be what vector 0 plays.
    assign fwd0     = wr_en && (vp.load_addr == '0);
    assign vec0_ui  = fwd0 ? vp.load_ui  : mem_ui_q[0];
    assign vec0_uio = fwd0 ? vp.load_uio : mem_uio_q[0];

    assign num_in = (vp.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : vp.num_vec;
    assign idx_nx = idx_q + AW'(1);

    // The oldest tag names the vector whose response is on dut_uo this edge.
    assign cmp_idx  = tag_idx_q[LAT-1];
    assign mismatch = tag_vld_q[LAT-1] &&
                      (|((vp.dut_uo ^ mem_exp_q[cmp_idx]) & mem_mask_q[cmp_idx]));

`ifdef VP_HALT_ON_ERR_EN
    assign halt = mismatch;
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_ui_q[vp.load_addr]   <= vp.load_ui;
            mem_uio_q[vp.load_addr]  <= vp.load_uio;
            mem_exp_q[vp.load_addr]  <= vp.load_exp;
            mem_mask_q[vp.load_addr] <= vp.load_mask;
        end
    end

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ui_d       = ui_q;
        uio_d      = uio_q;
        pass_d     = pass_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        launch     = 1'b0;
        launch_idx = idx_q;

        if (state_q == S_IDLE && vp.start) begin
            err_d  = '0;
            ferr_d = '0;
        end else if (mismatch) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (err_q == '0) ferr_d = cmp_idx;
        end

        case (state_q)
            S_IDLE: begin
                if (vp.start) begin
                    num_d  = num_in;
                    idx_d  = '0;
                    cnt_d  = '0;
                    pass_d = 1'b0;
                    if (num_in != '0) begin
                        state_d    = S_RUN;
                        launch     = 1'b1;
                        launch_idx = '0;
                        ui_d       = vec0_ui;
                        uio_d      = vec0_uio;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!halt && (({1'b0, idx_q} + (AW+1)'(1)) < num_q)) begin
                    launch     = 1'b1;
                    launch_idx = idx_nx;
                    idx_d      = idx_nx;
                    ui_d       = mem_ui_q[idx_nx];
                    uio_d      = mem_uio_q[idx_nx];
                end else begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LCW'(LAT-1)) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    cnt_d = cnt_q + LCW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ui_d    = '0;
                uio_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            ui_q      <= '0;
            uio_q     <= '0;
            err_q     <= '0;
            ferr_q    <= '0;
            pass_q    <= 1'b0;
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) tag_idx_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            ui_q         <= ui_d;
            uio_q        <= uio_d;
            err_q        <= err_d;
            ferr_q       <= ferr_d;
            pass_q       <= pass_d;
            tag_vld_q[0] <= launch;
            tag_idx_q[0] <= launch_idx;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    assign vp.ui_drv        = ui_q;
    assign vp.uio_drv       = uio_q;
    assign vp.busy          = busy;
    assign vp.done          = (state_q == S_DONE);
    assign vp.pass          = pass_q;
    assign vp.err_count     = err_q;
    assign vp.first_err_idx = ferr_q;
endmodule

// File: tb/tb_tt_vector_player.sv
module tb_tt_vector_player;
    localparam int IO_W    = 8;
    localparam int DEPTH   = 16;
    localparam int LAT     = 1;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    tt_vector_player_if #(.IO_W(IO_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) vp ();

    tt_vector_player #(.IO_W(IO_W), .DEPTH(DEPTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .vp  (vp)
    );

    always #5 clk = ~clk;

    // Stand-in user project: uo_out = ui_in + 1, purely combinational (LAT=1).
    assign vp.dut_uo = vp.ui_drv + 8'd1;

    // Reference copy of the vector memory.
    logic [7:0] m_ui [DEPTH];
    logic [7:0] m_uio[DEPTH];
    logic [7:0] m_exp[DEPTH];
    logic [7:0] m_msk[DEPTH];

    // Expected outputs for the current cycle, maintained by the stimulus.
    bit         chk_en = 1'b0;
    logic       exp_busy, exp_done, exp_pass;
    logic [7:0] exp_ui, exp_uio;
    int         exp_err, exp_ferr;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      vp.busy,      exp_busy);
            chk("done",      vp.done,      exp_done);
            chk("pass",      vp.pass,      exp_pass);
            chk("ui_drv",    vp.ui_drv,    exp_ui);
            chk("uio_drv",   vp.uio_drv,   exp_uio);
            chk("err_count", vp.err_count, exp_err);
            if (exp_err != 0) chk("first_err_idx", vp.first_err_idx, exp_ferr);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_reset_exp();
        exp_busy = 0; exp_done = 0; exp_pass = 0;
        exp_ui = '0; exp_uio = '0; exp_err = 0; exp_ferr = 0;
    endtask

    // Called at posedge+1; writes one entry and returns at the next posedge+1.
    task automatic load_vec(input int a, input logic [7:0] u, input logic [7:0] io,
                            input logic [7:0] e, input logic [7:0] m);
        vp.load_en   = 1'b1;
        vp.load_addr = 4'(a);
        vp.load_ui   = u;
        vp.load_uio  = io;
        vp.load_exp  = e;
        vp.load_mask = m;
        m_ui[a] = u; m_uio[a] = io; m_exp[a] = e; m_msk[a] = m;
        @(posedge clk); #1;
        vp.load_en = 1'b0;
    endtask

    // One run: start at the next edge, check every cycle, return in IDLE.
    // abort_t >= 0 asserts rst for one edge after post-start edge abort_t.
    // seen = post-start edge after which done was observed, or -1.
    task automatic run(input int nv, input int abort_t, input bit co_load,
                       input bit rnd, output int seen);
        int n, f, x, d, cnt, fk, idx;
        bit mm[DEPTH];
        bit aborted;
        logic [7:0] tmp;
        n = (nv > DEPTH) ? DEPTH : nv;
        vp.start   = 1'b1;
        vp.num_vec = 5'(nv);
        if (co_load) begin
            tmp = 8'($urandom);
            vp.load_en   = 1'b1;
            vp.load_addr = '0;
            vp.load_ui   = tmp;
            vp.load_uio  = 8'($urandom);
            vp.load_exp  = ($urandom_range(1) == 0) ? tmp + 8'd1 : 8'($urandom);
            vp.load_mask = 8'($urandom);
            m_ui[0] = vp.load_ui; m_uio[0] = vp.load_uio;
            m_exp[0] = vp.load_exp; m_msk[0] = vp.load_mask;
        end
        f = -1;
        for (int k = 0; k < DEPTH; k++) begin
            tmp   = m_ui[k] + 8'd1;
            mm[k] = |((tmp ^ m_exp[k]) & m_msk[k]);
            if (k < n && mm[k] && f < 0) f = k;
        end
        x = n;
`ifdef VP_HALT_ON_ERR_EN
        if (f >= 0 && f + LAT < n) x = f + LAT;
`endif
        d = (n == 0) ? 0 : x + LAT;
        seen = -1;
        aborted = 1'b0;
        for (int t = 0; t <= d + 1; t++) begin
            @(posedge clk); #1;
            vp.start   = 1'b0;
            vp.load_en = 1'b0;
            if (aborted) begin
                rst = 1'b0;
                set_reset_exp();
                break;
            end
            cnt = 0; fk = -1;
            for (int k = 0; k < x; k++)
                if (mm[k] && k + LAT <= t) begin
                    cnt++;
                    if (fk < 0) fk = k;
                end
            exp_busy = (n > 0) && (t < d);
            exp_done = (t == d);
            exp_pass = (t >= d) && (cnt == 0);
            exp_err  = (cnt > CNT_MAX) ? CNT_MAX : cnt;
            exp_ferr = (fk < 0) ? 0 : fk;
            if (n == 0 || t > d) begin
                exp_ui = '0; exp_uio = '0;
            end else begin
                idx = (t < x) ? t : x - 1;
                exp_ui = m_ui[idx]; exp_uio = m_uio[idx];
            end
            if (vp.done) seen = t;
            if (t == abort_t) begin
                rst = 1'b1;
                aborted = 1'b1;
                continue;
            end
            if (rnd && t <= d && $urandom_range(7) == 0) begin
                vp.start   = 1'b1;
                vp.num_vec = 5'($urandom);
            end
            if (rnd && t < d && $urandom_range(5) == 0) begin
                vp.load_en   = 1'b1;
                vp.load_addr = 4'($urandom);
                vp.load_ui   = 8'($urandom);
                vp.load_uio  = 8'($urandom);
                vp.load_exp  = 8'($urandom);
                vp.load_mask = 8'($urandom);
            end
        end
    endtask

    initial begin
        int seen;
        logic [7:0] u;
        rst = 1'b1;
        vp.load_en = 0; vp.load_addr = '0; vp.load_ui = '0; vp.load_uio = '0;
        vp.load_exp = '0; vp.load_mask = '0; vp.start = 0; vp.num_vec = '0;
        set_reset_exp();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", vp.busy, 0);
        chk("rst_done", vp.done, 0);
        chk("rst_pass", vp.pass, 0);
        chk("rst_ui",   vp.ui_drv, 0);
        chk("rst_err",  vp.err_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++)
            load_vec(i, 8'(i * 17 + 3), 8'(i * 5), 8'(i * 17 + 4), 8'hFF);

        // T1: four correct vectors
        run(4, -1, 0, 0, seen);
        chk("T1_done_cycles", seen + 1, 6);
        chk("T1_pass", vp.pass, 1);
        chk("T1_err", vp.err_count, 0);

        // T2: vector 2 differs only in masked-off bits
        u = m_ui[2] + 8'd1;
        load_vec(2, m_ui[2], m_uio[2], u ^ 8'h0F, 8'hF0);
        run(4, -1, 0, 0, seen);
        chk("T2_pass", vp.pass, 1);
        chk("T2_err", vp.err_count, 0);

        // T3: vectors 1 and 3 wrong
        load_vec(1, 8'h53, 8'h11, 8'h55, 8'hFF);
        u = m_ui[3] + 8'd1;
        load_vec(3, m_ui[3], m_uio[3], ~u, 8'hFF);
        run(4, -1, 0, 0, seen);
`ifdef VP_HALT_ON_ERR_EN
        chk("T3_err", vp.err_count, 1);
`else
        chk("T3_err", vp.err_count, 2);
`endif
        chk("T3_first", vp.first_err_idx, 1);
        chk("T3_pass", vp.pass, 0);

        // T4: empty run
        run(0, -1, 0, 0, seen);
        chk("T4_done_cycles", seen + 1, 1);
        chk("T4_pass", vp.pass, 1);

        // T5: every vector wrong, counter saturates
        for (int i = 0; i < DEPTH; i++) begin
            u = 8'($urandom);
            load_vec(i, u, 8'($urandom), (u + 8'd1) ^ 8'h80, 8'hFF);
        end
        run(16, -1, 0, 0, seen);
`ifdef VP_HALT_ON_ERR_EN
        chk("T5_err", vp.err_count, 1);
`else
        chk("T5_err", vp.err_count, 3);
`endif
        chk("T5_first", vp.first_err_idx, 0);

        // T6: reset mid-run, then a single-vector run
        for (int i = 0; i < 8; i++) begin
            u = 8'($urandom);
            load_vec(i, u, 8'($urandom), u + 8'd1, 8'hFF);
        end
        run(8, 2, 0, 0, seen);
        chk("T6_no_done", seen, -1);
        chk("T6_busy", vp.busy, 0);
        chk("T6_ui", vp.ui_drv, 0);
        repeat (3) begin @(posedge clk); #1; end
        run(1, -1, 0, 0, seen);
        chk("T6_restart_done", seen, 1 + LAT);
        chk("T6_restart_pass", vp.pass, 1);

        // Randomized runs with ignored start/load pulses and start+load overlap
        repeat (30) begin
            repeat ($urandom_range(4)) begin
                u = 8'($urandom);
                load_vec($urandom_range(DEPTH - 1), u, 8'($urandom),
                         ($urandom_range(3) == 0) ? 8'($urandom) : u + 8'd1,
                         ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom));
            end
            run($urandom_range(31), -1, $urandom_range(3) == 0, 1, seen);
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
